lif_spike_decoder: RTL and testbench



---
 rtl/lif_spike_decoder.sv | 176 +++++++++++++++++
 tb/tb_lif_spike_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_spike_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lif_spike_decoder
//
// Receive-side decoder for the LIF neuron's 1-bit spike train. Turns the spike
// train back into two numbers:
//   * a windowed firing rate (spike count over the last completed window of
//     L = 32 << window_sel enabled cycles), and
//   * an inter-spike interval (enabled cycles between the last two events).
// Each result has a registered one-cycle valid strobe.
//
// Parameters
//   CNT_W     : width of rate/isi outputs and their counters (saturate at
//               2^CNT_W-1).
//   EDGE_MODE : 1 = an event is a rising edge of spike,
//               0 = an event is every cycle spike is high.
//
// Ports
//   clk        : system clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   ena        : enable; low freezes counters/window and ignores spike
//   spike      : spike train, synchronous to clk
//   window_sel : rate window select, sampled only at window boundaries
//   rate       : spike count of the last completed window (saturating)
//   rate_valid : one-cycle strobe, rate updated
//   rate_sat   : last completed window's count saturated
//   isi        : cycles between the last two events (saturating)
//   isi_valid  : one-cycle strobe, isi updated (not on the first event)
// -----------------------------------------------------------------------------
module lif_spike_decoder #(
  parameter int CNT_W     = 8,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike,
  input  logic [1:0]       window_sel,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid
);

  // The longest window is 256 cycles, so the window counter is 8 bits
  // regardless of CNT_W.
  localparam int WCNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // State registers
  logic              spike_q_reg;
  logic [WCNT_W-1:0] wcnt_reg,      wcnt_next;
  logic [CNT_W-1:0]  spike_cnt_reg, spike_cnt_next;
  logic              cnt_sat_reg,   cnt_sat_next;
  logic [1:0]        sel_q_reg,     sel_q_next;
  logic [CNT_W-1:0]  isi_cnt_reg,   isi_cnt_next;
  logic              have_prev_reg, have_prev_next;
  logic [CNT_W-1:0]  rate_reg,      rate_next;
  logic              rate_valid_reg, rate_valid_next;
  logic              rate_sat_reg,  rate_sat_next;
  logic [CNT_W-1:0]  isi_reg,       isi_next;
  logic              isi_valid_reg, isi_valid_next;

  logic       evt;
  logic       win_last;
  logic [3:0] win_end_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  // In edge mode a spike already high when ena rises counts only if it was
  // low on the previous cycle, because spike_q keeps tracking during ena=0.
  assign evt = EDGE_MODE ? (spike & ~spike_q_reg) : spike;

  // One comparator per window length; only the one matching the latched
  // select can fire, so a mid-window window_sel change cannot cut a window.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_win_end
      localparam logic [WCNT_W-1:0] LAST = WCNT_W'((32 << gi) - 1);
      assign win_end_hit[gi] = (sel_q_reg == 2'(gi)) && (wcnt_reg == LAST);
    end
  endgenerate

  assign win_last = |win_end_hit;

  always_comb begin
    wcnt_next       = wcnt_reg;
    spike_cnt_next  = spike_cnt_reg;
    cnt_sat_next    = cnt_sat_reg;
    sel_q_next      = sel_q_reg;
    isi_cnt_next    = isi_cnt_reg;
    have_prev_next  = have_prev_reg;
    rate_next       = rate_reg;
    rate_sat_next   = rate_sat_reg;
    isi_next        = isi_reg;
    rate_valid_next = 1'b0;
    isi_valid_next  = 1'b0;

    if (ena) begin
      // ---------------- rate window ----------------
      if (win_last) begin
        // An event on the closing cycle still belongs to this window.
        if ((spike_cnt_reg == CNT_MAX) && evt) begin
          rate_next     = CNT_MAX;
          rate_sat_next = 1'b1;
        end else begin
          rate_next     = spike_cnt_reg + CNT_W'(evt);
          rate_sat_next = cnt_sat_reg;
        end
        rate_valid_next = 1'b1;
        spike_cnt_next  = '0;
        cnt_sat_next    = 1'b0;
        wcnt_next       = '0;
        sel_q_next      = window_sel;
      end else begin
        wcnt_next = wcnt_reg + WCNT_W'(1);
        if (evt) begin
          if (spike_cnt_reg == CNT_MAX) begin
            cnt_sat_next = 1'b1;
          end else begin
            spike_cnt_next = spike_cnt_reg + CNT_W'(1);
          end
        end
      end

      // ---------------- inter-spike interval ----------------
      if (evt) begin
        isi_next       = sat_inc(isi_cnt_reg);
        isi_valid_next = have_prev_reg;
        isi_cnt_next   = '0;
        have_prev_next = 1'b1;
      end else begin
        isi_cnt_next = sat_inc(isi_cnt_reg);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q_reg    <= 1'b0;
      wcnt_reg       <= '0;
      spike_cnt_reg  <= '0;
      cnt_sat_reg    <= 1'b0;
      sel_q_reg      <= '0;
      isi_cnt_reg    <= '0;
      have_prev_reg  <= 1'b0;
      rate_reg       <= '0;
      rate_valid_reg <= 1'b0;
      rate_sat_reg   <= 1'b0;
      isi_reg        <= '0;
      isi_valid_reg  <= 1'b0;
    end else begin
      spike_q_reg    <= spike;
      wcnt_reg       <= wcnt_next;
      spike_cnt_reg  <= spike_cnt_next;
      cnt_sat_reg    <= cnt_sat_next;
      sel_q_reg      <= sel_q_next;
      isi_cnt_reg    <= isi_cnt_next;
      have_prev_reg  <= have_prev_next;
      rate_reg       <= rate_next;
      rate_valid_reg <= rate_valid_next;
      rate_sat_reg   <= rate_sat_next;
      isi_reg        <= isi_next;
      isi_valid_reg  <= isi_valid_next;
    end
  end

  assign rate       = rate_reg;
  assign rate_valid = rate_valid_reg;
  assign rate_sat   = rate_sat_reg;
  assign isi        = isi_reg;
  assign isi_valid  = isi_valid_reg;

endmodule

// File: tb/tb_lif_spike_decoder.sv
`timescale 1ns/1ps
// Testbench for lif_spike_decoder. Two instances (level mode and edge mode)
// share one stimulus stream. A behavioural model counts events per window with
// plain integers and measures ISI as a difference of enabled-cycle indices.
module tb_lif_spike_decoder;

  localparam int MAXV = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       spike;
  logic [1:0] window_sel;

  logic [7:0] rate0, isi0, rate1, isi1;
  logic       rv0, rs0, iv0, rv1, rs1, iv1;

  always #5 clk = ~clk;

  lif_spike_decoder #(.CNT_W(8), .EDGE_MODE(1'b0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike), .window_sel(window_sel),
    .rate(rate0), .rate_valid(rv0), .rate_sat(rs0), .isi(isi0), .isi_valid(iv0)
  );

  lif_spike_decoder #(.CNT_W(8), .EDGE_MODE(1'b1)) u_edge (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike), .window_sel(window_sel),
    .rate(rate1), .rate_valid(rv1), .rate_sat(rs1), .isi(isi1), .isi_valid(iv1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: index 0 = level mode, 1 = edge mode.
  int m_wpos, m_wlen, m_en_t;
  bit m_prev;
  int m_cnt [2];
  int m_last [2];
  bit m_hasp [2];
  int e_rate [2];
  int e_isi [2];
  bit e_rs [2];
  bit e_rv [2];
  bit e_iv [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wpos = 0; m_wlen = 32; m_en_t = 0; m_prev = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_last[m] = -1; m_hasp[m] = 1'b0;
      e_rate[m] = 0; e_isi[m] = 0; e_rs[m] = 1'b0; e_rv[m] = 1'b0; e_iv[m] = 1'b0;
    end
  endtask

  // Expected outputs after the next rising edge, given the inputs applied.
  task automatic model_step(input bit s, input bit en, input logic [1:0] ws);
    bit ev [2];
    int gap;
    ev[0] = s;
    ev[1] = s && !m_prev;
    for (int m = 0; m < 2; m++) begin
      e_rv[m] = 1'b0;
      e_iv[m] = 1'b0;
    end
    if (en) begin
      for (int m = 0; m < 2; m++) begin
        if (ev[m]) begin
          m_cnt[m]++;
          gap = m_en_t - m_last[m];
          e_isi[m] = (gap > MAXV) ? MAXV : gap;
          e_iv[m] = m_hasp[m];
          m_hasp[m] = 1'b1;
          m_last[m] = m_en_t;
        end
      end
      m_wpos++;
      if (m_wpos == m_wlen) begin
        for (int m = 0; m < 2; m++) begin
          e_rate[m] = (m_cnt[m] > MAXV) ? MAXV : m_cnt[m];
          e_rs[m] = (m_cnt[m] > MAXV);
          e_rv[m] = 1'b1;
          m_cnt[m] = 0;
        end
        m_wpos = 0;
        m_wlen = 32 << ws;
      end
      m_en_t++;
    end
    m_prev = s;
  endtask

  task automatic compare_all();
    check("lvl.rate",       rate0, e_rate[0]);
    check("lvl.rate_valid", rv0,   e_rv[0]);
    check("lvl.rate_sat",   rs0,   e_rs[0]);
    check("lvl.isi",        isi0,  e_isi[0]);
    check("lvl.isi_valid",  iv0,   e_iv[0]);
    check("edg.rate",       rate1, e_rate[1]);
    check("edg.rate_valid", rv1,   e_rv[1]);
    check("edg.rate_sat",   rs1,   e_rs[1]);
    check("edg.isi",        isi1,  e_isi[1]);
    check("edg.isi_valid",  iv1,   e_iv[1]);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit s, input bit en, input logic [1:0] ws);
    spike = s; ena = en; window_sel = ws;
    model_step(s, en, ws);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset applied away from any clock edge; outputs must clear
  // immediately.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.lvl.rate", rate0, 0);
    check("rst.lvl.rv",   rv0,   0);
    check("rst.lvl.rs",   rs0,   0);
    check("rst.lvl.isi",  isi0,  0);
    check("rst.lvl.iv",   iv0,   0);
    check("rst.edg.rate", rate1, 0);
    check("rst.edg.rv",   rv1,   0);
    check("rst.edg.rs",   rs1,   0);
    check("rst.edg.isi",  isi1,  0);
    check("rst.edg.iv",   iv1,   0);
    spike = 1'b0; ena = 1'b0; window_sel = 2'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  initial begin
    int density;
    bit s, en;
    logic [1:0] ws;
    rst_n = 1'b0; ena = 1'b0; spike = 1'b0; window_sel = 2'd0;
    model_reset();
    @(negedge clk);

    // A: spikes every 4 cycles, 32-cycle window
    do_reset();
    for (int k = 0; k < 33; k++) begin
      step(k % 4 == 0, 1'b1, 2'd0);
      if (k == 28) begin
        check("A.isi", isi1, 4);
        check("A.isi_valid", iv1, 1);
      end
      if (k == 30) check("A.rv_early", rv1, 0);
      if (k == 31) begin
        check("A.rate_edge", rate1, 8);
        check("A.rate_lvl", rate0, 8);
        check("A.rate_valid", rv1, 1);
      end
      if (k == 32) check("A.rv_one_cycle", rv1, 0);
    end

    // B: spike held high for 10 cycles
    do_reset();
    for (int k = 0; k < 32; k++) begin
      step(k >= 2 && k < 12, 1'b1, 2'd0);
      if (k == 11) check("B.edge_no_isi_valid", iv1, 0);
      if (k == 31) begin
        check("B.rate_edge", rate1, 1);
        check("B.rate_lvl", rate0, 10);
      end
    end

    // C: ISI 7, then a 300-cycle gap saturates
    do_reset();
    for (int k = 0; k < 309; k++) begin
      step(k == 0 || k == 7 || k == 307, 1'b1, 2'd0);
      if (k == 7) begin
        check("C.isi7", isi1, 7);
        check("C.isi7_valid", iv1, 1);
      end
      if (k == 307) begin
        check("C.isi_sat", isi1, 255);
        check("C.isi_sat_valid", iv1, 1);
      end
      if (k == 308) check("C.iv_one_cycle", iv1, 0);
    end

    // D: 256-cycle window fully high, then 3 spikes
    do_reset();
    for (int k = 0; k < 544; k++) begin
      step((k >= 32 && k < 288) || k == 300 || k == 310 || k == 320, 1'b1, 2'd3);
      if (k == 287) begin
        check("D.rate_lvl_sat", rate0, 255);
        check("D.rate_sat", rs0, 1);
        check("D.rv", rv0, 1);
        check("D.rate_edge", rate1, 1);
      end
      if (k == 543) begin
        check("D.rate_lvl_3", rate0, 3);
        check("D.rate_sat_clear", rs0, 0);
        check("D.rv2", rv0, 1);
      end
    end

    // E: 20 disabled cycles mid-window, window_sel 0->1 mid-window
    do_reset();
    for (int k = 0; k < 116; k++) begin
      en = !(k >= 10 && k < 30);
      s  = (k == 2 || k == 5 || k == 40 || k == 60) || (!en && (k % 2 == 0));
      step(s, en, (k >= 15) ? 2'd1 : 2'd0);
      if (k == 31) check("E.rv_not_at_32", rv1, 0);
      if (k == 51) begin
        check("E.rv_delayed", rv1, 1);
        check("E.rate_edge", rate1, 3);
        check("E.rate_lvl", rate0, 3);
      end
      if (k == 83) check("E.no_32_window", rv0, 0);
      if (k == 115) begin
        check("E.rv_64", rv0, 1);
        check("E.rate_64", rate1, 1);
      end
    end

    // F: async reset mid-window with 5 counted spikes
    for (int k = 0; k < 20; k++) step(k % 4 == 1, 1'b1, 2'd1);
    do_reset();
    for (int k = 0; k < 32; k++) begin
      step(k == 3 || k == 20, 1'b1, 2'd0);
      if (k == 30) check("F.rv_early", rv1, 0);
      if (k == 31) begin
        check("F.rv", rv1, 1);
        check("F.rate_edge", rate1, 2);
        check("F.rate_lvl", rate0, 2);
      end
    end

    // Random traffic with varying spike density
    ws = 2'd0;
    density = 30;
    for (int it = 0; it < 3000; it++) begin
      if (it % 400 == 0) begin
        case ($urandom_range(0, 3))
          0: density = 4;
          1: density = 30;
          2: density = 70;
          default: density = 99;
        endcase
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      if ($urandom_range(0, 49) == 0) ws = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 9) != 0);
      s  = ($urandom_range(0, 99) < density);
      step(s, en, ws);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
